// File: rtl/rr_arbiter_param.sv
// Packet-aware round-robin arbiter: holds a grant until done, request drop or timeout,
// then rotates priority so the releasing requester is searched last.
module rr_arbiter_param #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 0,
  parameter int TO_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam bit            TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [TO_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [TO_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic                 timeout_q, timeout_d;

  logic                 owner_req;
  logic                 to_hit;
  logic                 release_now;
  logic [ID_W-1:0]      rel_ptr;
  logic [ID_W-1:0]      arb_ptr;
  logic                 found;
  logic [ID_W-1:0]      win;

  assign owner_req   = req[gnt_id_q];
  assign to_hit      = TO_EN && (hold_cnt_q == TO_LAST);
  assign release_now = done | ~owner_req | to_hit;
  assign rel_ptr     = ID_W'((int'(gnt_id_q) + 1) % NUM_REQ);
  // A releasing grant re-arbitrates from the rotated pointer in the same cycle.
  assign arb_ptr     = (state_q == GRANT) ? rel_ptr : ptr_q;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(arb_ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        if (found) begin
          gnt_d[win]  = 1'b1;
          gnt_id_d    = win;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = rel_ptr;
          // Flag a timeout only when nothing else would have ended the grant.
          timeout_d = to_hit & ~done & owner_req;
          if (found) begin
            gnt_d       = '0;
            gnt_d[win]  = 1'b1;
            gnt_id_d    = win;
            gnt_valid_d = 1'b1;
            hold_cnt_d  = '0;
          end else begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
